// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the MIPS front end: instruction width, the default
// fetch timeout, the fetch FSM state encoding and a word-alignment helper.
// -----------------------------------------------------------------------------
package mips_pkg;

  localparam int INSTR_W = 32;

  // Default number of cycles a fetch waits for a memory response.
  localparam int unsigned FETCH_TIMEOUT_DEFAULT = 255;

  // Fetch FSM state encoding (3 bits).
  localparam logic [2:0] FETCH_IDLE  = 3'd0;
  localparam logic [2:0] FETCH_REQ   = 3'd1;
  localparam logic [2:0] FETCH_WAIT  = 3'd2;
  localparam logic [2:0] FETCH_HOLD  = 3'd3;
  localparam logic [2:0] FETCH_DROP  = 3'd4;
  localparam logic [2:0] FETCH_FAULT = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE  = FETCH_IDLE,
    ST_REQ   = FETCH_REQ,
    ST_WAIT  = FETCH_WAIT,
    ST_HOLD  = FETCH_HOLD,
    ST_DROP  = FETCH_DROP,
    ST_FAULT = FETCH_FAULT
  } fetch_state_e;

  // True when the address points at the start of a 32-bit word.
  function automatic logic is_word_aligned(input logic [INSTR_W-1:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/fetch_timeout_counter.sv
// -----------------------------------------------------------------------------
// fetch_timeout_counter
// 16-bit saturating cycle counter used by the fetch unit to bound the time it
// waits for an instruction-memory response.
//
// Ports:
//   clk      in   clock
//   reset_n  in   asynchronous active-low reset
//   clear    in   zero the count (takes priority over enable)
//   enable   in   count this cycle
//   expired  out  count >= TIMEOUT_CYCLES
// -----------------------------------------------------------------------------
module fetch_timeout_counter
  import mips_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = FETCH_TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [15:0] LIMIT = 16'(TIMEOUT_CYCLES);

  logic [15:0] count;

  // NOTE: state registers use non-blocking assignments and an asynchronous
  // reset in the sensitivity list so every flop clears the moment reset_n
  // falls, independent of the clock.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != 16'hFFFF)) begin
      count <= count + 16'd1;
    end
  end

  // The count holds the number of cycles already completed in WAIT/DROP, so
  // the limit is seen on the cycle after TIMEOUT_CYCLES full cycles elapsed.
  assign expired = (count >= LIMIT);

endmodule

// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
// Instruction fetch stage: reads one word at `pc` from instruction memory over
// a valid/ready request channel, holds the returned instruction for decode and
// pulses `pc_en` so the PC register advances. Handles redirects (flush),
// misaligned PCs and memory-response timeouts.
//
// Ports:
//   clk, reset_n      clock, asynchronous active-low reset
//   pc                current PC (changes only on an edge where pc_en=1)
//   pc_en             PC register load enable (one-cycle pulse)
//   imem_req_*        request channel to instruction memory
//   imem_rsp_*        single-cycle response strobe and data
//   instr/instr_valid/instr_ready   handshake towards decode
//   flush             redirect: a new target is waiting on next_pc
//   misaligned        sticky flag, pc[1:0] != 0 seen in REQ
//   imem_timeout      sticky flag, a WAIT exceeded TIMEOUT_CYCLES
// -----------------------------------------------------------------------------
module instr_fetch_unit
  import mips_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = FETCH_TIMEOUT_DEFAULT
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [INSTR_W-1:0] pc,
  output logic               pc_en,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [INSTR_W-1:0] imem_req_addr,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rsp_data,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  input  logic               instr_ready,
  input  logic               flush,
  output logic               misaligned,
  output logic               imem_timeout
);

  fetch_state_e state;

  logic pc_aligned;
  logic req_fire;
  logic cnt_clear;
  logic cnt_enable;
  logic expired;

  assign pc_aligned = is_word_aligned(pc);

  // A flush in REQ withdraws the request: the PC is about to change, and an
  // accepted request would leave a response in flight for the wrong address.
  assign imem_req_valid = (state == ST_REQ) && pc_aligned && !flush;
  assign imem_req_addr  = imem_req_valid ? pc : '0;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // instr_valid comes straight from the state register, so it is glitch-free.
  assign instr_valid = (state == ST_HOLD);

  // pc_en must be seen by the PC register on the same edge that completes the
  // decode handshake or the redirect, so it is decoded combinationally.
  assign pc_en = (flush && (state != ST_IDLE)) || (instr_valid && instr_ready);

  // The counter restarts on entry to WAIT (request accepted) and on entry to
  // DROP (flush in WAIT without a coincident response).
  assign cnt_clear  = req_fire || ((state == ST_WAIT) && flush && !imem_rsp_valid);
  assign cnt_enable = (state == ST_WAIT) || (state == ST_DROP);

  fetch_timeout_counter #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (cnt_clear),
    .enable  (cnt_enable),
    .expired (expired)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_IDLE;
      instr        <= '0;
      misaligned   <= 1'b0;
      imem_timeout <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: state <= ST_REQ;

        ST_REQ: begin
          if (flush) begin
            state <= ST_REQ;
          end else if (!pc_aligned) begin
            state      <= ST_FAULT;
            misaligned <= 1'b1;
          end else if (imem_req_ready) begin
            state <= ST_WAIT;
          end
        end

        ST_WAIT: begin
          if (flush) begin
            // A response in the flush cycle closes the transaction, so there
            // is nothing left to drain.
            state <= imem_rsp_valid ? ST_REQ : ST_DROP;
          end else if (imem_rsp_valid) begin
            instr <= imem_rsp_data;
            state <= ST_HOLD;
          end else if (expired) begin
            imem_timeout <= 1'b1;
            state        <= ST_REQ;
          end
        end

        ST_HOLD: begin
          if (flush || instr_ready) begin
            state <= ST_REQ;
          end
        end

        // Drain the response of the flushed request; its data is discarded
        // and a timeout here is not reported.
        ST_DROP: begin
          if (flush || imem_rsp_valid || expired) begin
            state <= ST_REQ;
          end
        end

        ST_FAULT: begin
          if (flush) begin
            state <= ST_REQ;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_unit
// Directed bench for instr_fetch_unit with TIMEOUT_CYCLES=8. The bench plays
// instruction memory and decode by hand and models the PC register, which
// loads next_pc on every edge where pc_en=1.
// -----------------------------------------------------------------------------
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] pc = 32'h0;
  logic [31:0] next_pc;
  logic        pc_en;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic        flush;
  logic        misaligned;
  logic        imem_timeout;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // PC register model.
  always @(posedge clk) begin
    if (pc_en) pc <= next_pc;
  end

  instr_fetch_unit #(
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .pc             (pc),
    .pc_en          (pc_en),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .instr          (instr),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .flush          (flush),
    .misaligned     (misaligned),
    .imem_timeout   (imem_timeout)
  );

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Advance one clock; leaves time 2 units after the rising edge.
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  // One fetch with a zero-wait memory and a ready decoder: REQ, WAIT, HOLD.
  task automatic fetch_zero_wait(input logic [31:0] addr, input logic [31:0] data,
                                 input logic [31:0] nxt);
    imem_req_ready = 1'b1;
    #1;
    check("zw_req_valid", imem_req_valid, 1);
    check("zw_req_addr", imem_req_addr, addr);
    check("zw_pc_en_req", pc_en, 0);
    cyc();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = data;
    #1;
    check("zw_instr_valid_wait", instr_valid, 0);
    check("zw_req_valid_wait", imem_req_valid, 0);
    cyc();
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    instr_ready    = 1'b1;
    next_pc        = nxt;
    #1;
    check("zw_instr_valid_hold", instr_valid, 1);
    check("zw_instr", instr, data);
    check("zw_pc_en_hold", pc_en, 1);
    cyc();
    instr_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n        = 1'b0;
    next_pc        = 32'h0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    instr_ready    = 1'b0;
    flush          = 1'b0;

    // ---- reset values ----
    #1;
    check("rst_pc_en", pc_en, 0);
    check("rst_req_valid", imem_req_valid, 0);
    check("rst_req_addr", imem_req_addr, 0);
    check("rst_instr", instr, 0);
    check("rst_instr_valid", instr_valid, 0);
    check("rst_misaligned", misaligned, 0);
    check("rst_timeout", imem_timeout, 0);
    cyc();
    cyc();
    reset_n = 1'b1;
    #1;
    check("idle_req_valid", imem_req_valid, 0);
    cyc();  // IDLE -> REQ

    // ---- zero-wait stream 0x0, 0x4, 0x8 ----
    fetch_zero_wait(32'h0, 32'h20080001, 32'h4);
    fetch_zero_wait(32'h4, 32'h8C090000, 32'h8);
    fetch_zero_wait(32'h8, 32'h01095020, 32'hC);

    // ---- request stall, delayed response, decode back-pressure ----
    imem_req_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("stall_req_valid", imem_req_valid, 1);
      check("stall_req_addr", imem_req_addr, 32'hC);
      check("stall_pc_en", pc_en, 0);
      cyc();
    end
    imem_req_ready = 1'b1;
    #1;
    check("stall_accept_addr", imem_req_addr, 32'hC);
    cyc();  // WAIT
    imem_req_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      check("delay_instr_valid", instr_valid, 0);
      cyc();
    end
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h8C080004;
    #1;
    cyc();  // HOLD
    for (int i = 0; i < 5; i++) begin
      // A stray response in HOLD must not disturb the held instruction.
      imem_rsp_valid = (i == 2);
      imem_rsp_data  = (i == 2) ? 32'hFFFFFFFF : 32'h0;
      #1;
      check("bp_instr_valid", instr_valid, 1);
      check("bp_instr", instr, 32'h8C080004);
      check("bp_pc_en", pc_en, 0);
      cyc();
    end
    imem_rsp_valid = 1'b0;
    instr_ready    = 1'b1;
    next_pc        = 32'h10;
    #1;
    check("bp_accept_pc_en", pc_en, 1);
    cyc();
    instr_ready = 1'b0;

    // ---- flush in WAIT, stale response dropped ----
    imem_req_ready = 1'b1;
    #1;
    check("fw_req_addr", imem_req_addr, 32'h10);
    cyc();  // WAIT
    imem_req_ready = 1'b0;
    flush          = 1'b1;
    next_pc        = 32'h40;
    #1;
    check("fw_pc_en", pc_en, 1);
    cyc();  // DROP
    flush = 1'b0;
    #1;
    check("drop_instr_valid", instr_valid, 0);
    check("drop_req_valid", imem_req_valid, 0);
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hDEADBEEF;
    #1;
    cyc();  // REQ
    imem_rsp_valid = 1'b0;
    #1;
    check("fw_redirect_valid", imem_req_valid, 1);
    check("fw_redirect_addr", imem_req_addr, 32'h40);
    check("fw_timeout", imem_timeout, 0);
    imem_req_ready = 1'b1;
    cyc();  // WAIT
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h24020005;
    #1;
    cyc();  // HOLD
    imem_rsp_valid = 1'b0;
    #1;
    check("fw_new_instr", instr, 32'h24020005);
    instr_ready = 1'b1;
    next_pc     = 32'h44;
    #1;
    check("fw_accept_pc_en", pc_en, 1);
    cyc();
    instr_ready = 1'b0;

    // ---- flush and response in the same WAIT cycle -> REQ, not DROP ----
    imem_req_ready = 1'b1;
    #1;
    cyc();  // WAIT
    imem_req_ready = 1'b0;
    flush          = 1'b1;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hBADC0DE0;
    next_pc        = 32'h48;
    #1;
    check("fr_pc_en", pc_en, 1);
    cyc();
    flush          = 1'b0;
    imem_rsp_valid = 1'b0;
    #1;
    check("fr_req_valid", imem_req_valid, 1);
    check("fr_req_addr", imem_req_addr, 32'h48);
    check("fr_instr_valid", instr_valid, 0);

    // ---- flush together with decode accept in HOLD ----
    imem_req_ready = 1'b1;
    cyc();  // WAIT
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h11111111;
    #1;
    cyc();  // HOLD
    imem_rsp_valid = 1'b0;
    flush          = 1'b1;
    instr_ready    = 1'b1;
    next_pc        = 32'h60;
    #1;
    check("fh_pc_en", pc_en, 1);
    check("fh_instr", instr, 32'h11111111);
    cyc();
    flush       = 1'b0;
    instr_ready = 1'b0;
    #1;
    check("fh_instr_valid", instr_valid, 0);
    check("fh_req_addr", imem_req_addr, 32'h60);

    // ---- misaligned PC -> FAULT, exited by flush ----
    flush   = 1'b1;
    next_pc = 32'h6;
    #1;
    check("ma_flush_req_valid", imem_req_valid, 0);
    check("ma_flush_pc_en", pc_en, 1);
    cyc();  // REQ with pc=0x6
    flush          = 1'b0;
    imem_req_ready = 1'b1;
    #1;
    check("ma_req_valid", imem_req_valid, 0);
    check("ma_req_addr", imem_req_addr, 0);
    cyc();  // FAULT
    #1;
    check("ma_flag", misaligned, 1);
    check("ma_fault_req_valid", imem_req_valid, 0);
    check("ma_fault_instr_valid", instr_valid, 0);
    cyc();
    #1;
    check("ma_fault_stays", imem_req_valid, 0);
    check("ma_fault_pc_en", pc_en, 0);
    imem_req_ready = 1'b0;
    flush          = 1'b1;
    next_pc        = 32'h80;
    #1;
    check("ma_exit_pc_en", pc_en, 1);
    cyc();  // REQ with pc=0x80
    flush = 1'b0;
    #1;
    check("ma_exit_req_valid", imem_req_valid, 1);
    check("ma_exit_req_addr", imem_req_addr, 32'h80);
    check("ma_sticky", misaligned, 1);

    // ---- timeout while draining in DROP is not reported ----
    imem_req_ready = 1'b1;
    #1;
    cyc();  // WAIT
    imem_req_ready = 1'b0;
    flush          = 1'b1;
    next_pc        = 32'h80;
    #1;
    cyc();  // DROP
    flush = 1'b0;
    for (int i = 0; i < 9; i++) begin
      #1;
      check("dto_req_valid", imem_req_valid, 0);
      cyc();
    end
    #1;
    check("dto_timeout", imem_timeout, 0);
    check("dto_req_valid_after", imem_req_valid, 1);

    // ---- WAIT timeout, same address re-requested ----
    imem_req_ready = 1'b1;
    cyc();  // WAIT
    imem_req_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      #1;
      check("wto_timeout_low", imem_timeout, 0);
      check("wto_req_valid", imem_req_valid, 0);
      cyc();
    end
    #1;
    check("wto_timeout", imem_timeout, 1);
    check("wto_rereq_valid", imem_req_valid, 1);
    check("wto_rereq_addr", imem_req_addr, 32'h80);
    fetch_zero_wait(32'h80, 32'h3C010000, 32'h84);
    #1;
    check("wto_sticky", imem_timeout, 1);

    // ---- reset during WAIT ----
    imem_req_ready = 1'b1;
    cyc();  // WAIT
    imem_req_ready = 1'b0;
    reset_n        = 1'b0;
    #1;
    check("mr_pc_en", pc_en, 0);
    check("mr_req_valid", imem_req_valid, 0);
    check("mr_req_addr", imem_req_addr, 0);
    check("mr_instr", instr, 0);
    check("mr_instr_valid", instr_valid, 0);
    check("mr_misaligned", misaligned, 0);
    check("mr_timeout", imem_timeout, 0);
    cyc();
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hAAAAAAAA;
    reset_n        = 1'b1;
    #1;
    check("mr_idle_req_valid", imem_req_valid, 0);
    check("mr_idle_instr_valid", instr_valid, 0);
    cyc();  // REQ
    imem_rsp_valid = 1'b0;
    #1;
    check("mr_req_valid_after", imem_req_valid, 1);
    check("mr_req_addr_after", imem_req_addr, 32'h84);
    check("mr_instr_after", instr, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch stage directly downstream of the program-counter register in the monocycle MIPS. It takes the current `pc`, issues one word read to instruction memory over a valid/ready request channel, and captures the response. It holds the instruction for decode under a valid/ready handshake, then pulses `pc_en` so the PC register loads `next_pc`. It also handles redirect flushes, misaligned PCs and memory-response timeouts.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 255: cycles spent waiting for a response before the request is abandoned. Legal range is 1–65535.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `pc`  in  32  current PC from the PC register. Stable except on an edge where `pc_en`=1.
- `pc_en`  out  1  one-cycle pulse; the PC register loads `next_pc` on that edge.
- `imem_req_valid`  out  1  request to instruction memory is valid.
- `imem_req_ready`  in  1  instruction memory accepts the request.
- `imem_req_addr`  out  32  word address; equals `pc` while `imem_req_valid`=1.
- `imem_rsp_valid`  in  1  response data is valid (single-cycle strobe).
- `imem_rsp_data`  in  32  instruction word.
- `instr`  out  32  captured instruction for decode.
- `instr_valid`  out  1  `instr` is valid.
- `instr_ready`  in  1  decode consumes `instr`.
- `flush`  in  1  redirect: upstream has placed a new target on `next_pc`.
- `misaligned`  out  1  sticky fault flag, set when `pc[1:0]`≠0.
- `imem_timeout`  out  1  sticky flag, set when a response exceeds `TIMEOUT_CYCLES`; cleared only by reset.

## Operation
States: IDLE, REQ, WAIT, HOLD, DROP, FAULT.
- **IDLE:** entered on reset. Moves unconditionally to REQ on the next cycle.
- **REQ:**
  - If `pc[1:0]`≠0: go to FAULT and set `misaligned`. No request is issued.
  - Otherwise drive `imem_req_valid`=1 with `imem_req_addr`=`pc`. On `imem_req_ready`=1, go to WAIT.
- **WAIT:**
  - On `imem_rsp_valid`: capture `imem_rsp_data` into `instr` and go to HOLD.
  - If the counter reaches `TIMEOUT_CYCLES`: set `imem_timeout` and go to REQ (re-issue the same `pc`).
- **HOLD:** `instr_valid`=1. When `instr_ready`=1, drive `pc_en`=1 (combinational, same cycle) and go to REQ.
- **DROP:** waits for the outstanding response or a timeout, discards the data, then goes to REQ. `imem_timeout` is not set by a timeout in DROP.
- **FAULT:** no requests are issued and `instr_valid`=0. Only `flush` or reset exits this state.
- **flush (any state except IDLE):**
  - `pc_en`=1 in that cycle.
  - Next state is DROP if the current state is WAIT, else REQ.
  - `instr_valid` is 0 from the next cycle.
  - A response arriving in the same cycle as `flush` in WAIT is discarded and the state goes to REQ, not DROP.
- **Timeout counter:** 16 bits. Cleared on entry to WAIT or DROP, increments each cycle in those states, saturates.
- **flush with HOLD and `instr_ready`=1 in the same cycle:** the handshake completes, `pc_en` pulses once, next state is REQ.
- A response outside WAIT/DROP is ignored.

## Timing
- **Reset values (asynchronous):** state=IDLE; `instr`=0; `instr_valid`, `pc_en`, `imem_req_valid`, `misaligned`, `imem_timeout` all 0. `imem_req_addr` is 0 while invalid.
- **Reset mid-transaction:** any outstanding memory response is abandoned. Memory must tolerate this.
- **Memory response timing:** the response arrives no earlier than the cycle after request acceptance.
- **Latency:** request accepted at cycle N, earliest `instr_valid` at N+2.
- **Throughput:** with a zero-wait memory and a ready consumer, one instruction every 3 cycles (REQ, WAIT, HOLD).
- **Request stability:** `imem_req_valid` and `imem_req_addr` stay stable until accepted. `instr` is stable while `instr_valid`=1.

## Structure
- Shared package `mips_pkg`:
  - state encoding constants `FETCH_IDLE` … `FETCH_FAULT` (3 bits);
  - `INSTR_W`=32;
  - default `TIMEOUT_CYCLES`.
- Sub-module `fetch_timeout_counter`: inputs clear and enable, output `expired` when count ≥ `TIMEOUT_CYCLES`. Its state is reset by `reset_n`.
- The PC register gains a load enable driven by `pc_en`.

## Test plan
- Zero-wait memory, `pc`=0x0, 0x4, 0x8, `instr_ready`=1 → `imem_req_addr` sequence 0x0/0x4/0x8, `instr_valid` every 3rd cycle, one `pc_en` pulse per instruction.
- Memory stalls `imem_req_ready` 4 cycles, response delayed 3 cycles; decode holds `instr_ready`=0 for 5 cycles → address stable, `instr`=0x8C080004 held, no `pc_en` until accept.
- `flush` while in WAIT, then stale response 0xDEADBEEF → response discarded, new request to redirected `pc`=0x40, `imem_timeout`=0.
- `pc`=0x6 → `misaligned`=1, no `imem_req_valid`; `flush` with `next_pc`=0x80 → request to 0x80 issued.
- No response with `TIMEOUT_CYCLES`=8 → `imem_timeout`=1 after 8 WAIT cycles, same address re-requested.
- `reset_n` low during WAIT → all outputs 0 immediately; after release, IDLE then REQ with the current `pc`.
